dot_rom_arbiter: RTL and testbench

DOT_ROM_ARBITER -- requirements
Module: dot_rom_arbiter

---
 rtl/dot_rom_arbiter.sv | 154 +++++++++++++++
 tb/tb_dot_rom_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_rom_arbiter.sv
// Round-robin arbiter sharing one dot ROM read port among NUM_REQ requesters.
// Latency: grant edge -> rom_addr valid; next edge -> rd_valid/ack one-cycle pulse.
// Backpressure: none downstream; a requester with a fetch in flight is not eligible until its ack has passed.
//
// Ports:
//   clk, rst_n     sole clock (rising edge), asynchronous active-low reset
//   req, req_row   per-requester level request and 3-bit sprite row ([3i+2:3i])
//   rom_addr       registered row address to the external dot ROM
//   rom_data       combinational ROM output for rom_addr
//   ack            one-hot, one-cycle completion pulse
//   rd_data/rd_id  fetched row and owning requester, valid while rd_valid
//   busy           a fetch occupies stage 1 or stage 2

`ifndef DOT_WIDTH
`define DOT_WIDTH 8
`endif

module dot_rom_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DOT_WIDTH = `DOT_WIDTH,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [3*NUM_REQ-1:0]   req_row,
    output logic [2:0]             rom_addr,
    input  logic [DOT_WIDTH-1:0]   rom_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic [DOT_WIDTH-1:0]   rd_data,
    output logic [ID_W-1:0]        rd_id,
    output logic                   rd_valid,
    output logic                   busy
);

    // Pointer starts at the last requester so requester 0 is searched first.
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

    // Stage 1: granted fetch, ROM address presented.
    logic                 r_v1;
    logic [ID_W-1:0]      r_id1;
    logic [2:0]           r_rom_addr;
    logic [ID_W-1:0]      r_ptr;

    // Stage 2: ROM data captured, completion reported.
    logic                 r_rd_valid;
    logic [ID_W-1:0]      r_rd_id;
    logic [DOT_WIDTH-1:0] r_rd_data;
    logic [NUM_REQ-1:0]   r_ack;

    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_gnt_vld;
    logic [ID_W-1:0]      w_gnt_id;
    logic [2:0]           w_gnt_row;
    logic [NUM_REQ-1:0]   w_id1_onehot;

    // A requester whose fetch sits in either stage is masked so it can never
    // hold two fetches at once; this also enforces one grant per 3 cycles each.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req[i]
                      & ~(r_v1       & (r_id1   == ID_W'(i)))
                      & ~(r_rd_valid & (r_rd_id == ID_W'(i)));
        end
    end

    // Round-robin search from r_ptr+1 upward with wrap, done as two ordered
    // passes over constant indices: first those above the pointer, then those
    // at or below it. The first eligible hit in that order wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_gnt_vld && w_elig[i] && (ID_W'(i) > r_ptr)) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_gnt_vld && w_elig[i] && (ID_W'(i) <= r_ptr)) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = ID_W'(i);
            end
        end
    end

    // Row of the winner, sampled at the grant edge.
    always_comb begin
        w_gnt_row = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_id == ID_W'(i)) begin
                w_gnt_row = req_row[3*i +: 3];
            end
        end
    end

    always_comb begin
        w_id1_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_id1_onehot[i] = (r_id1 == ID_W'(i));
        end
    end

    // Stage 1 registers. rom_addr and id1 hold when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1       <= 1'b0;
            r_id1      <= '0;
            r_rom_addr <= '0;
            r_ptr      <= PTR_RST;
        end else begin
            r_v1 <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_id1      <= w_gnt_id;
                r_rom_addr <= w_gnt_row;
                r_ptr      <= w_gnt_id;
            end
        end
    end

    // Stage 2 registers. rd_id/rd_data hold between fetches; ack is a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_id    <= '0;
            r_rd_data  <= '0;
            r_ack      <= '0;
        end else begin
            r_rd_valid <= r_v1;
            if (r_v1) begin
                r_rd_id   <= r_id1;
                r_rd_data <= rom_data;
                r_ack     <= w_id1_onehot;
            end else begin
                r_ack     <= '0;
            end
        end
    end

    assign rom_addr = r_rom_addr;
    assign ack      = r_ack;
    assign rd_data  = r_rd_data;
    assign rd_id    = r_rd_id;
    assign rd_valid = r_rd_valid;
    assign busy     = r_v1 | r_rd_valid;

    // ack is a single pulse that always coincides with rd_valid.
    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(r_ack));
    a_ack_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (|r_ack) == r_rd_valid);

endmodule

// File: tb/tb_dot_rom_arbiter.sv
`ifndef DOT_WIDTH
`define DOT_WIDTH 8
`endif

module tb_dot_rom_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [3*N-1:0]  req_row;
    logic [2:0]      rom_addr;
    logic [DW-1:0]   rom_data;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rd_data;
    logic [IW-1:0]   rd_id;
    logic            rd_valid;
    logic            busy;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    // Filled-circle sprite held in the external dot ROM.
    function automatic logic [DW-1:0] rom_fn(input logic [2:0] row);
        case (row)
            3'd0: rom_fn = 8'h3C;
            3'd1: rom_fn = 8'h7E;
            3'd6: rom_fn = 8'h7E;
            3'd7: rom_fn = 8'h3C;
            default: rom_fn = 8'hFF;
        endcase
    endfunction

    assign rom_data = rom_fn(rom_addr);

    dot_rom_arbiter #(.NUM_REQ(N), .DOT_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_row(req_row),
        .rom_addr(rom_addr), .rom_data(rom_data), .ack(ack),
        .rd_data(rd_data), .rd_id(rd_id), .rd_valid(rd_valid), .busy(busy)
    );

    // ---------------- reference model ----------------
    // A grant at edge t completes (ack) at edge t+1; the requester may not be
    // granted again before edge t+3.
    typedef struct {
        int         due;
        int         id;
        logic [2:0] row;
    } fetch_t;

    fetch_t       q[$];
    int           t_edge = 0;
    int           busy_until[N];
    int           last_g;
    logic [2:0]   exp_rom_addr;
    logic [N-1:0] exp_ack;
    logic [DW-1:0] exp_rd_data;
    logic [IW-1:0] exp_rd_id;
    logic         exp_rd_valid;
    logic         exp_busy;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < N; i++) busy_until[i] = -100;
        last_g       = N - 1;
        exp_rom_addr = '0;
        exp_ack      = '0;
        exp_rd_data  = '0;
        exp_rd_id    = '0;
        exp_rd_valid = 1'b0;
        exp_busy     = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] rq, input logic [3*N-1:0] rows);
        fetch_t f;
        int g;
        t_edge++;
        exp_ack      = '0;
        exp_rd_valid = 1'b0;
        if (q.size() > 0 && q[0].due == t_edge) begin
            f = q.pop_front();
            exp_rd_valid = 1'b1;
            exp_ack      = N'(1) << f.id;
            exp_rd_id    = IW'(f.id);
            exp_rd_data  = rom_fn(f.row);
        end
        g = -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last_g + k) % N;
            if (g < 0 && rq[i] && t_edge > busy_until[i]) g = i;
        end
        if (g >= 0) begin
            busy_until[g] = t_edge + 2;
            last_g        = g;
            f.due         = t_edge + 1;
            f.id          = g;
            f.row         = rows[3*g +: 3];
            exp_rom_addr  = f.row;
            q.push_back(f);
        end
        exp_busy = (q.size() > 0) || exp_rd_valid;
    endtask

    // Leaves the bench at a falling edge with reset released; the next
    // rising edge is the first one that can grant.
    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        req_row = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n   = 1'b0;
        req     = '0;
        req_row = '0;
        #2;
        n_vec++;
        if ({rom_addr, ack, rd_valid, rd_id, rd_data, busy} !== '0) begin
            n_mis++;
            $display("FAIL reset_outputs: got addr=%h ack=%b vld=%b id=%0d data=%h busy=%b, expected all zero",
                     rom_addr, ack, rd_valid, rd_id, rd_data, busy);
        end
        do_reset();
        @(posedge clk); #1;
        n_vec++;
        if (busy !== 1'b0 || ack !== '0) begin
            n_mis++;
            $display("FAIL reset_idle: got busy=%b ack=%b, expected 0/0000", busy, ack);
        end
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        do_reset();
        req = 4'b0100;
        req_row = 12'b000_001_000_000;
        @(posedge clk); #1;
        n_vec++;
        if (rom_addr !== 3'd1 || busy !== 1'b1 || ack !== '0) begin
            n_mis++;
            $display("FAIL single_edge1: got addr=%0d busy=%b ack=%b, expected 1/1/0000", rom_addr, busy, ack);
        end
        @(posedge clk); #1;
        n_vec++;
        if (ack !== 4'b0100 || rd_id !== 2'd2 || rd_data !== 8'h7E || rd_valid !== 1'b1) begin
            n_mis++;
            $display("FAIL single_edge2: got ack=%b id=%0d data=%h vld=%b, expected 0100/2/7e/1",
                     ack, rd_id, rd_data, rd_valid);
        end
        @(negedge clk);
        req = '0;
        @(posedge clk); #1;
        n_vec++;
        if (ack !== '0 || rd_valid !== 1'b0 || busy !== 1'b0 || rd_data !== 8'h7E) begin
            n_mis++;
            $display("FAIL single_edge3: got ack=%b vld=%b busy=%b data=%h, expected 0000/0/0/7e (held)",
                     ack, rd_valid, busy, rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_all_four();
        logic [DW-1:0] exp_d [4];
        exp_d[0] = 8'h3C; exp_d[1] = 8'h7E; exp_d[2] = 8'hFF; exp_d[3] = 8'hFF;
        do_reset();
        req = 4'b1111;
        req_row = 12'b011_010_001_000;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (ack !== (4'b0001 << k) || rd_id !== IW'(k) || rd_data !== exp_d[k]) begin
                n_mis++;
                $display("FAIL all_four_ack%0d: got ack=%b id=%0d data=%h, expected %b/%0d/%h",
                         k, ack, rd_id, rd_data, 4'b0001 << k, k, exp_d[k]);
            end
            if (k == 3) begin
                n_vec++;
                if (rom_addr !== 3'd0) begin
                    n_mis++;
                    $display("FAIL all_four_regrant: got addr=%0d, expected 0", rom_addr);
                end
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if (ack !== 4'b0001) begin
            n_mis++;
            $display("FAIL all_four_wrap_ack: got ack=%b, expected 0001", ack);
        end
        @(negedge clk);
    endtask

    task automatic test_alternate();
        logic [N-1:0] exp_a;
        do_reset();
        req = 4'b0011;
        req_row = '0;
        @(posedge clk);
        for (int e = 2; e <= 13; e++) begin
            @(posedge clk); #1;
            case ((e - 2) % 3)
                0: exp_a = 4'b0001;
                1: exp_a = 4'b0010;
                default: exp_a = 4'b0000;
            endcase
            n_vec++;
            if (ack !== exp_a) begin
                n_mis++;
                $display("FAIL alternate_edge%0d: got ack=%b, expected %b", e, ack, exp_a);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single_req3();
        do_reset();
        req = 4'b1000;
        req_row = 12'b111_000_000_000;
        @(posedge clk);
        for (int e = 2; e <= 10; e++) begin
            @(posedge clk); #1;
            n_vec++;
            if ((e - 2) % 3 == 0) begin
                if (ack !== 4'b1000 || rd_data !== 8'h3C) begin
                    n_mis++;
                    $display("FAIL req3_edge%0d: got ack=%b data=%h, expected 1000/3c", e, ack, rd_data);
                end
            end else if (ack !== '0) begin
                n_mis++;
                $display("FAIL req3_gap%0d: got ack=%b, expected 0000", e, ack);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        req_row = 12'b000_110_000_000;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({rom_addr, ack, rd_valid, rd_id, rd_data, busy} !== '0) begin
            n_mis++;
            $display("FAIL reset_mid_async: got addr=%h ack=%b vld=%b id=%0d data=%h busy=%b, expected all zero",
                     rom_addr, ack, rd_valid, rd_id, rd_data, busy);
        end
        req = 4'b1001;
        req_row = 12'b010_000_000_101;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (rom_addr !== 3'd5 || ack !== '0 || busy !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_mid_first: got addr=%0d ack=%b busy=%b, expected 5/0000/1", rom_addr, ack, busy);
        end
        @(posedge clk); #1;
        n_vec++;
        if (ack !== 4'b0001 || rd_id !== 2'd0 || rd_data !== 8'hFF) begin
            n_mis++;
            $display("FAIL reset_mid_ack: got ack=%b id=%0d data=%h, expected 0001/0/ff", ack, rd_id, rd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_pulse();
        do_reset();
        req = 4'b0011;
        req_row = '0;
        @(posedge clk);
        @(negedge clk);
        req = 4'b0001;
        for (int e = 2; e <= 9; e++) begin
            @(posedge clk); #1;
            n_vec++;
            if (ack[1] !== 1'b0) begin
                n_mis++;
                $display("FAIL pulse_edge%0d: got ack=%b, expected ack[1]=0", e, ack);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                #1;
                n_vec++;
                if ({rom_addr, ack, rd_valid, busy} !== '0) begin
                    n_mis++;
                    $display("FAIL rand_reset c=%0d: got addr=%h ack=%b vld=%b busy=%b, expected zero",
                             c, rom_addr, ack, rd_valid, busy);
                end
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            if ($urandom_range(0, 1) == 0) req_row = (3*N)'($urandom);
            @(posedge clk);
            model_edge(req, req_row);
            #1;
            n_vec++;
            if (rom_addr !== exp_rom_addr || ack !== exp_ack || rd_valid !== exp_rd_valid) begin
                n_mis++;
                $display("FAIL rand_ctl c=%0d: got addr=%0d ack=%b vld=%b, expected %0d/%b/%b",
                         c, rom_addr, ack, rd_valid, exp_rom_addr, exp_ack, exp_rd_valid);
            end
            n_vec++;
            if (rd_id !== exp_rd_id || rd_data !== exp_rd_data || busy !== exp_busy) begin
                n_mis++;
                $display("FAIL rand_data c=%0d: got id=%0d data=%h busy=%b, expected %0d/%h/%b",
                         c, rd_id, rd_data, busy, exp_rd_id, exp_rd_data, exp_busy);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_fetch();
        test_all_four();
        test_alternate();
        test_single_req3();
        test_reset_mid();
        test_pulse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
